// File: rtl/rm_pc_stack.sv
// rm_pc_stack: registered program counter with a LIFO hardware return stack.
// Drives the fetch address onto the A input of the address multiplexer.
// Overflow/underflow raise a sticky fault that the control unit can clear.
module rm_pc_stack #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           target,
  input  logic                       clear_fault,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       fault
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_JMP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;

  op_t              op_e;
  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [DW-1:0]    depth_next;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic             push;
  logic             fault_set;
  logic             fault_next;

  assign op_e        = op_t'(op);
  assign pc_inc      = pc + WIDTH'(1);
  assign stack_empty = (depth == '0);
  assign stack_full  = (depth == DW'(DEPTH));
  // Entry addresses come from the low bits of depth; a full stack wraps the
  // low bits to zero, so depth-1 still lands on the top entry.
  assign push_idx    = depth[AW-1:0];
  assign top_idx     = depth[AW-1:0] - AW'(1);

  // Next-state decode of the requested operation and the sticky fault.
  always_comb begin
    pc_next    = pc;
    depth_next = depth;
    push       = 1'b0;
    fault_set  = 1'b0;
    if (enable) begin
      unique case (op_e)
        OP_INC: pc_next = pc_inc;
        OP_JMP: pc_next = target;
        OP_CALL: begin
          if (stack_full) begin
            fault_set = 1'b1;
          end else begin
            push       = 1'b1;
            depth_next = depth + DW'(1);
            pc_next    = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            fault_set = 1'b1;
          end else begin
            pc_next    = stack_mem[top_idx];
            depth_next = depth - DW'(1);
          end
        end
        default: pc_next = pc;
      endcase
    end
    if (fault_set)        fault_next = 1'b1;
    else if (clear_fault) fault_next = 1'b0;
    else                  fault_next = fault;
  end

  // PC, depth and fault registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_ADDR;
      depth <= '0;
      fault <= 1'b0;
    end else begin
      pc    <= pc_next;
      depth <= depth_next;
      fault <= fault_next;
    end
  end

  // Return-stack storage; a call pushes the wrapped return address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else if (push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_rm_pc_stack.sv
// Testbench for rm_pc_stack: directed vector table, reset corner cases and
// randomized operations checked against a queue-based reference model.
module tb_rm_pc_stack;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] target = 8'h00;
  logic       clear_fault = 1'b0;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       stack_empty;
  logic       stack_full;
  logic       fault;

  int checks = 0;
  int errors = 0;

  rm_pc_stack #(.WIDTH(8), .DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .target(target),
    .clear_fault(clear_fault), .pc(pc), .depth(depth),
    .stack_empty(stack_empty), .stack_full(stack_full), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] op;
    logic [7:0] tgt;
    logic       cf;
    logic [7:0] pc;
    int         d;
    logic       f;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int e_pc, input int e_d, input int e_f);
    chk({tag, ".pc"}, int'(pc), e_pc);
    chk({tag, ".depth"}, int'(depth), e_d);
    chk({tag, ".empty"}, int'(stack_empty), (e_d == 0) ? 1 : 0);
    chk({tag, ".full"}, int'(stack_full), (e_d == DEPTH) ? 1 : 0);
    chk({tag, ".fault"}, int'(fault), e_f);
  endtask

  task automatic drive(input logic en, input logic [1:0] o, input logic [7:0] t, input logic cf);
    enable = en; op = o; target = t; clear_fault = cf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic [1:0] o, input logic [7:0] t, input logic cf,
                     input logic [7:0] p, input int d, input logic f);
    vec_t v;
    v.en = en; v.op = o; v.tgt = t; v.cf = cf; v.pc = p; v.d = d; v.f = f;
    vq.push_back(v);
  endtask

  // Reference model state
  int   m_pc;
  int   m_stack[$];
  logic m_fault;

  initial begin
    // INC=0 JMP=1 CALL=2 RET=3
    add(1, 2'd1, 8'hFE, 0, 8'hFE, 0, 0);
    add(1, 2'd0, 8'h00, 0, 8'hFF, 0, 0);
    add(1, 2'd0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 2'd0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 2'd1, 8'h77, 0, 8'h00, 0, 0);
    add(0, 2'd2, 8'h55, 0, 8'h00, 0, 0);
    add(1, 2'd1, 8'h05, 0, 8'h05, 0, 0);
    add(1, 2'd2, 8'h40, 0, 8'h40, 1, 0);
    add(1, 2'd0, 8'h00, 0, 8'h41, 1, 0);
    add(1, 2'd3, 8'h00, 0, 8'h06, 0, 0);
    add(1, 2'd1, 8'h10, 0, 8'h10, 0, 0);
    add(1, 2'd2, 8'h20, 0, 8'h20, 1, 0);
    add(1, 2'd2, 8'h30, 0, 8'h30, 2, 0);
    add(1, 2'd2, 8'h40, 0, 8'h40, 3, 0);
    add(1, 2'd2, 8'h50, 0, 8'h50, 4, 0);
    add(1, 2'd2, 8'h60, 0, 8'h50, 4, 1);
    add(1, 2'd3, 8'h00, 0, 8'h41, 3, 1);
    add(1, 2'd3, 8'h00, 0, 8'h31, 2, 1);
    add(1, 2'd3, 8'h00, 0, 8'h21, 1, 1);
    add(1, 2'd3, 8'h00, 0, 8'h11, 0, 1);
    add(1, 2'd0, 8'h00, 1, 8'h12, 0, 0);
    add(1, 2'd3, 8'h00, 0, 8'h12, 0, 1);
    add(1, 2'd3, 8'h00, 1, 8'h12, 0, 1);
    add(1, 2'd0, 8'h00, 1, 8'h13, 0, 0);
    add(1, 2'd3, 8'h00, 0, 8'h13, 0, 1);
    add(0, 2'd3, 8'h00, 1, 8'h13, 0, 0);
    add(1, 2'd1, 8'hFF, 0, 8'hFF, 0, 0);
    add(1, 2'd2, 8'h80, 0, 8'h80, 1, 0);
    add(1, 2'd3, 8'h00, 0, 8'h00, 0, 0);

    // Asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1 chk_all("reset", 8'h00, 0, 0);
    @(negedge clk) reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].op, vq[i].tgt, vq[i].cf);
      tick();
      chk_all($sformatf("vec%0d", i), int'(vq[i].pc), vq[i].d, int'(vq[i].f));
    end

    // Reset mid-operation with two entries on the stack
    drive(1, 2'd1, 8'h10, 0); tick();
    drive(1, 2'd2, 8'h30, 0); tick();
    drive(1, 2'd2, 8'h40, 0); tick();
    chk_all("prereset", 8'h40, 2, 0);
    drive(0, 2'd0, 8'h00, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_all("midreset", 8'h00, 0, 0);
    @(negedge clk) reset = 1'b0;
    drive(1, 2'd3, 8'h00, 0); tick();
    chk_all("ret_after_reset", 8'h00, 0, 1);

    // Randomized run against the reference model
    m_pc = 0;
    m_fault = 1'b1;
    m_stack.delete();
    for (int n = 0; n < 1500; n++) begin
      logic       en, cf, set_f;
      logic [1:0] o;
      logic [7:0] t;
      en = ($urandom_range(0, 7) != 0);
      o  = 2'($urandom_range(0, 3));
      t  = 8'($urandom_range(0, 255));
      cf = ($urandom_range(0, 5) == 0);
      set_f = 1'b0;
      if (en) begin
        case (o)
          2'd0: m_pc = (m_pc + 1) % 256;
          2'd1: m_pc = int'(t);
          2'd2: begin
            if (m_stack.size() == DEPTH) set_f = 1'b1;
            else begin
              m_stack.push_back((m_pc + 1) % 256);
              m_pc = int'(t);
            end
          end
          default: begin
            if (m_stack.size() == 0) set_f = 1'b1;
            else m_pc = m_stack.pop_back();
          end
        endcase
      end
      if (set_f) m_fault = 1'b1;
      else if (cf) m_fault = 1'b0;
      drive(en, o, t, cf);
      tick();
      chk_all($sformatf("rand%0d", n), m_pc, m_stack.size(), int'(m_fault));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
